// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller for the five-stage pipeline.
//
// Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from the E stage, computes
// the 64-bit result into pending registers when an operation starts, and runs
// a 4-bit busy countdown. The pending result is committed to HI/LO on the edge
// where the countdown goes 1->0. While busy, or while an op is starting, a
// D-stage multiply/divide instruction is held via md_stall.
//
// Optional feature macro: MDU_DIV0_GUARD_EN
//   defined   : div/divu with e_b == 0 does not start (no busy, no stall, HI/LO kept)
//   undefined : div/divu with e_b == 0 runs the normal countdown and commits
//               HI = e_a, LO = 0xFFFFFFFF
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high
//   e_valid    in   1   E-stage instruction is real
//   e_op       in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi,
//                       6 mflo, 7 mthi, 8 mtlo, 9..15 none
//   e_a        in  32   forwarded rs value
//   e_b        in  32   forwarded rt value
//   d_is_md    in   1   D-stage instruction is a multiply/divide op
//   busy       out  1   countdown in progress
//   md_stall   out  1   stall request for the D stage
//   e_rd_data  out 32   HI for mfhi, LO for mflo, else 0 (combinational)
//   hi         out 32   HI register
//   lo         out 32   LO register
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] e_rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // 64-bit product; sign-extending both operands makes the low 64 bits of the
  // unsigned product equal to the signed product.
  function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  // {remainder, quotient}. Signed division works on magnitudes so that
  // 0x80000000 / -1 naturally yields 0x80000000 rem 0; divide by zero gives
  // HI = dividend, LO = all ones.
  function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    mag_a = neg_a ? (32'd0 - a) : a;
    mag_b = neg_b ? (32'd0 - b) : b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = mag_a / mag_b;
      r = mag_a % mag_b;
      if (neg_a ^ neg_b) q = 32'd0 - q;
      else               q = q;
      if (neg_a) r = 32'd0 - r;
      else       r = r;
    end
    return {r, q};
  endfunction

  state_t      state_r, state_n_s;
  logic [3:0]  cnt_r, cnt_n_s;
  logic [31:0] hi_r, hi_n_s;
  logic [31:0] lo_r, lo_n_s;
  logic [31:0] p_hi_r, p_hi_n_s;
  logic [31:0] p_lo_r, p_lo_n_s;

  logic        is_mul_s, is_div_s, sgn_s, is_mthi_s, is_mtlo_s;
  logic        div0_block_s;
  logic        start_s, wr_hi_s, wr_lo_s;
  logic [63:0] res_s;

  // Decode the E-stage opcode.
  always_comb begin
    is_mul_s  = 1'b0;
    is_div_s  = 1'b0;
    sgn_s     = 1'b0;
    is_mthi_s = 1'b0;
    is_mtlo_s = 1'b0;
    case (e_op)
      4'd1:    begin is_mul_s = 1'b1; sgn_s = 1'b1; end
      4'd2:    begin is_mul_s = 1'b1; end
      4'd3:    begin is_div_s = 1'b1; sgn_s = 1'b1; end
      4'd4:    begin is_div_s = 1'b1; end
      4'd7:    begin is_mthi_s = 1'b1; end
      4'd8:    begin is_mtlo_s = 1'b1; end
      default: begin is_mul_s = 1'b0; end
    endcase
  end

`ifdef MDU_DIV0_GUARD_EN
  assign div0_block_s = is_div_s & (e_b == 32'd0);
`else
  assign div0_block_s = 1'b0;
`endif

  assign busy     = (cnt_r != 4'd0);
  assign start_s  = e_valid & (is_mul_s | is_div_s) & ~busy & ~div0_block_s;
  assign wr_hi_s  = e_valid & is_mthi_s & ~busy;
  assign wr_lo_s  = e_valid & is_mtlo_s & ~busy;
  assign md_stall = d_is_md & (busy | start_s);
  assign hi       = hi_r;
  assign lo       = lo_r;

  // Compute the result of the operation currently in E.
  always_comb begin
    if (is_mul_s)      res_s = mul_res(e_a, e_b, sgn_s);
    else if (is_div_s) res_s = div_res(e_a, e_b, sgn_s);
    else               res_s = 64'd0;
  end

  // mfhi/mflo read path, no internal bypass.
  always_comb begin
    case (e_op)
      4'd5:    e_rd_data = hi_r;
      4'd6:    e_rd_data = lo_r;
      default: e_rd_data = 32'd0;
    endcase
  end

  // Next-state logic: start/move writes in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    hi_n_s    = hi_r;
    lo_n_s    = lo_r;
    p_hi_n_s  = p_hi_r;
    p_lo_n_s  = p_lo_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          cnt_n_s   = is_div_s ? DIV_N : MULT_N;
          p_hi_n_s  = res_s[63:32];
          p_lo_n_s  = res_s[31:0];
          state_n_s = BUSY;
        end else if (wr_hi_s) begin
          hi_n_s = e_a;
        end else if (wr_lo_s) begin
          lo_n_s = e_a;
        end else begin
          state_n_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd1) begin
          cnt_n_s   = 4'd0;
          hi_n_s    = p_hi_r;
          lo_n_s    = p_lo_r;
          state_n_s = IDLE;
        end else begin
          cnt_n_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      p_hi_r  <= 32'd0;
      p_lo_r  <= 32'd0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      hi_r    <= hi_n_s;
      lo_r    <= lo_n_s;
      p_hi_r  <= p_hi_n_s;
      p_lo_r  <= p_lo_n_s;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: cycle-by-cycle vector table with hand-computed
// expected outputs, plus a hand-written reset-during-busy sequence.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_op;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic        d_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] e_rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .e_a       (e_a),
    .e_b       (e_b),
    .d_is_md   (d_is_md),
    .busy      (busy),
    .md_stall  (md_stall),
    .e_rd_data (e_rd_data),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        dmd;
    logic        x_busy;
    logic        x_stall;
    logic [31:0] x_rd;
    logic [31:0] x_hi;
    logic [31:0] x_lo;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic rst, input logic v, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic dmd,
                     input logic xb, input logic xs, input logic [31:0] xrd,
                     input logic [31:0] xhi, input logic [31:0] xlo);
    vec_t t;
    t.rst = rst; t.v = v; t.op = op; t.a = a; t.b = b; t.dmd = dmd;
    t.x_busy = xb; t.x_stall = xs; t.x_rd = xrd; t.x_hi = xhi; t.x_lo = xlo;
    vecs.push_back(t);
  endtask

  // n bubble cycles in E, d_is_md held at dmd
  task automatic add_idle(input int n, input logic dmd, input logic xb, input logic xs,
                          input logic [31:0] xhi, input logic [31:0] xlo);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, dmd, xb, xs, 32'd0, xhi, xlo);
  endtask

  // Drive one cycle of inputs after the rising edge, check at the falling edge.
  task automatic step(input vec_t t, input int idx);
    @(posedge clk);
    #1;
    reset   = t.rst;
    e_valid = t.v;
    e_op    = t.op;
    e_a     = t.a;
    e_b     = t.b;
    d_is_md = t.dmd;
    @(negedge clk);
    n_vec++;
    if (busy !== t.x_busy) begin
      n_miss++;
      $display("FAIL busy vec %0d: got %0b expected %0b", idx, busy, t.x_busy);
    end
    if (md_stall !== t.x_stall) begin
      n_miss++;
      $display("FAIL md_stall vec %0d: got %0b expected %0b", idx, md_stall, t.x_stall);
    end
    if (e_rd_data !== t.x_rd) begin
      n_miss++;
      $display("FAIL e_rd_data vec %0d: got %h expected %h", idx, e_rd_data, t.x_rd);
    end
    if (hi !== t.x_hi) begin
      n_miss++;
      $display("FAIL hi vec %0d: got %h expected %h", idx, hi, t.x_hi);
    end
    if (lo !== t.x_lo) begin
      n_miss++;
      $display("FAIL lo vec %0d: got %h expected %h", idx, lo, t.x_lo);
    end
  endtask

  initial begin
    vec_t h;
    reset   = 1'b1;
    e_valid = 1'b0;
    e_op    = 4'd0;
    e_a     = 32'd0;
    e_b     = 32'd0;
    d_is_md = 1'b0;

    //  rst   v     op    a              b              dmd   busy  stall rd             hi             lo
    add(1'b0, 1'b0, 4'd0, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         32'd0,         32'd0);
    // mthi in idle, visible next cycle; mfhi reads it
    add(1'b0, 1'b1, 4'd7, 32'h1234,      32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         32'd0,         32'd0);
    add(1'b0, 1'b1, 4'd5, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'h1234,      32'h1234,      32'd0);
    // mtlo with e_valid=0 is dropped
    add(1'b0, 1'b0, 4'd8, 32'h5555,      32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         32'h1234,      32'd0);
    add(1'b0, 1'b1, 4'd6, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         32'h1234,      32'd0);
    // op 12 behaves as none
    add(1'b0, 1'b1, 4'd12, 32'd3,        32'd3,         1'b1, 1'b0, 1'b0, 32'd0,         32'h1234,      32'd0);
    // mult with e_valid=0 does not start
    add(1'b0, 1'b0, 4'd1, 32'hFFFF_FFFD, 32'd7,         1'b1, 1'b0, 1'b0, 32'd0,         32'h1234,      32'd0);
    add(1'b0, 1'b1, 4'd8, 32'hA5A5,      32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         32'h1234,      32'd0);
    add(1'b0, 1'b0, 4'd0, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         32'h1234,      32'hA5A5);
    // mult -3*7 with mflo waiting in D: stall for start cycle plus 5 busy
    add(1'b0, 1'b1, 4'd1, 32'hFFFF_FFFD, 32'd7,         1'b1, 1'b0, 1'b1, 32'd0,         32'h1234,      32'hA5A5);
    add(1'b0, 1'b0, 4'd0, 32'd0,         32'd0,         1'b1, 1'b1, 1'b1, 32'd0,         32'h1234,      32'hA5A5);
    // second mult and an mthi during busy must be ignored
    add(1'b0, 1'b1, 4'd1, 32'd2,         32'd3,         1'b1, 1'b1, 1'b1, 32'd0,         32'h1234,      32'hA5A5);
    add(1'b0, 1'b1, 4'd7, 32'hDEAD,      32'd0,         1'b1, 1'b1, 1'b1, 32'd0,         32'h1234,      32'hA5A5);
    add_idle(2, 1'b1, 1'b1, 1'b1, 32'h1234, 32'hA5A5);
    add(1'b0, 1'b0, 4'd0, 32'd0,         32'd0,         1'b1, 1'b0, 1'b0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    add(1'b0, 1'b1, 4'd6, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    // multu 0xFFFFFFFF * 2
    add(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2,         1'b0, 1'b0, 1'b0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    add_idle(5, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    add_idle(1, 1'b0, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFE);
    // div -7 / 2
    add(1'b0, 1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 1'b0, 32'd0,         32'd1,         32'hFFFF_FFFE);
    add_idle(10, 1'b0, 1'b1, 1'b0, 32'd1, 32'hFFFF_FFFE);
    add_idle(1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // divu 7 / 2
    add(1'b0, 1'b1, 4'd4, 32'd7,         32'd2,         1'b0, 1'b0, 1'b0, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add_idle(10, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add_idle(1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd3);
    // div 0x80000000 / -1
    add(1'b0, 1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0,         32'd1,         32'd3);
    add_idle(10, 1'b0, 1'b1, 1'b0, 32'd1, 32'd3);
    add_idle(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h8000_0000);
    // div 5 / 0 with a dependent op in D
`ifdef MDU_DIV0_GUARD_EN
    add(1'b0, 1'b1, 4'd3, 32'd5,         32'd0,         1'b1, 1'b0, 1'b0, 32'd0,         32'd0,         32'h8000_0000);
    add_idle(3, 1'b0, 1'b0, 1'b0, 32'd0, 32'h8000_0000);
`else
    add(1'b0, 1'b1, 4'd3, 32'd5,         32'd0,         1'b1, 1'b0, 1'b1, 32'd0,         32'd0,         32'h8000_0000);
    add_idle(10, 1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0000);
    add_idle(1, 1'b0, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFF);
`endif

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Hand-written: reset while a divu is counting down (at cnt=3).
    h = '{rst: 1'b0, v: 1'b1, op: 4'd7, a: 32'h77, b: 32'd0, dmd: 1'b0,
          x_busy: 1'b0, x_stall: 1'b0, x_rd: 32'd0, x_hi: hi, x_lo: lo};
    step(h, 1000);
    h.op = 4'd4; h.a = 32'd100; h.b = 32'd7; h.x_hi = 32'h77;
    step(h, 1001);
    h.v = 1'b0; h.op = 4'd0; h.a = 32'd0; h.b = 32'd0; h.x_busy = 1'b1;
    for (int k = 1; k <= 7; k++) step(h, 1001 + k);
    h.rst = 1'b1;
    step(h, 1009);
    h.rst = 1'b0; h.x_busy = 1'b0; h.x_hi = 32'd0; h.x_lo = 32'd0;
    for (int k = 0; k < 12; k++) step(h, 1010 + k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It accepts mult/div/move operations from the E stage, runs a multi-cycle busy countdown, holds the HI/LO architectural registers, and commits results at the end of the countdown. While the unit is busy, it raises a stall request to the hazard logic so that a dependent D-stage instruction is held and a bubble is inserted into E.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- e_valid  in  1  the E-stage instruction is real (not a bubble, not being flushed)
- e_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as none
- e_a  in  32  forwarded rs value
- e_b  in  32  forwarded rt value
- d_is_md  in  1  the D-stage instruction is any of ops 1..8
- busy  out  1  countdown in progress
- md_stall  out  1  stall request for the D stage
- e_rd_data  out  32  HI for mfhi, LO for mflo, otherwise 0 (combinational)
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- start = e_valid & (e_op in 1..4) & !busy. On start, compute the result from e_a/e_b into the pending registers (p_hi, p_lo) and load cnt with MULT_CYCLES or DIV_CYCLES.
- mult: {p_hi,p_lo} = signed 64-bit product. multu: unsigned product.
- div: p_lo = quotient truncated toward zero; p_hi = remainder, with the sign of the dividend. 0x80000000 / -1 gives LO=0x80000000, HI=0. divu: unsigned quotient and remainder.
- cnt is 4 bits; busy = (cnt != 0). cnt decrements each cycle while nonzero. On the edge where cnt goes 1->0, hi<=p_hi and lo<=p_lo.
- mthi/mtlo with e_valid & !busy: write e_a to hi or lo at the next edge.
- mthi/mtlo/start while busy cannot occur under correct stalling. If it does occur, the operation is ignored and hi/lo/cnt are unaffected.
- md_stall = d_is_md & (busy | start).
- Division by zero: see Configuration.
- States: IDLE (cnt=0) -> BUSY (cnt=N..1) -> IDLE with commit. There is no other state.

## Timing
- Reset values: busy=0, md_stall=0, hi=0, lo=0, e_rd_data=0, cnt=0, p_hi=p_lo=0.
- start sampled at the edge ending cycle T. busy is high for cycles T+1..T+N, and hi/lo show the new result from cycle T+N+1.
- md_stall is asserted combinationally in cycle T if d_is_md is set, and stays high through T+N. The D instruction advances in T+N+1.
- mfhi/mflo in E read hi/lo combinationally. A stalled mfhi therefore sees the committed value in T+N+1.
- mthi/mtlo take effect from the cycle after the write edge. mfhi immediately after mthi relies on the forwarding path; this block provides no internal bypass.
- Reset during BUSY: cnt clears and the pending result is discarded. hi and lo return to 0 at that edge.
- N=1: busy is high for exactly one cycle.
- e_valid=0 blocks all writes and starts, whatever the value of e_op.

## Configuration
- MDU_DIV0_GUARD_EN defined:
  - div/divu with e_b=0 does not start.
  - busy stays 0 and hi/lo are unchanged.
  - md_stall is not raised by this op.
- MDU_DIV0_GUARD_EN undefined:
  - div/divu with e_b=0 runs the normal DIV_CYCLES countdown.
  - It commits HI=e_a and LO=0xFFFFFFFF.

## Test plan
- mult: e_a=-3, e_b=7 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also cover multu with 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- div: e_a=-7, e_b=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also cover divu with 7/2 -> lo=3, hi=1.
- Back-to-back: mult issued with d_is_md=1 (mflo) -> md_stall high for 6 cycles (start cycle plus 5 busy). mflo then reads the new lo. A second mult during busy is ignored.
- mthi with e_a=0x1234 in idle -> hi=0x1234 the next cycle. mtlo with e_valid=0 -> lo unchanged.
- Reset asserted at cnt=3 of a div -> next cycle busy=0, hi=lo=0, no later commit.
- div by zero with e_a=5: guard enabled -> busy never rises and hi/lo are unchanged. Guard disabled -> after 10 cycles, hi=5, lo=0xFFFFFFFF.
